// File: rtl/ac97_codec_link_if.sv
// ---------------------------------------------------------------------------
// ac97_codec_link_if
// Bundles the AC-link serial lines and the codec-side sample/status signals.
//   AC97_SYNCH_I     controller -> codec  frame sync
//   AC97_DATA_OUT_I  controller -> codec  serial command/playback data
//   AC97_DATA_IN_O   codec -> controller  serial status/read data/capture
//   ADC_LEFT_I/ADC_RIGHT_I   capture samples fed into the codec
//   PCM_LEFT_O/PCM_RIGHT_O   decoded playback samples, PCM_VALID_O pulse
//   DAC_RATE_O               register 2Ch content
//   CODEC_READY_O            codec-ready status bit
// master: the controller/environment side; slave: the codec endpoint.
// ---------------------------------------------------------------------------
interface ac97_codec_link_if;
  logic        AC97_SYNCH_I;
  logic        AC97_DATA_OUT_I;
  logic        AC97_DATA_IN_O;
  logic [15:0] ADC_LEFT_I;
  logic [15:0] ADC_RIGHT_I;
  logic [15:0] PCM_LEFT_O;
  logic [15:0] PCM_RIGHT_O;
  logic        PCM_VALID_O;
  logic [15:0] DAC_RATE_O;
  logic        CODEC_READY_O;

  modport master (
    output AC97_SYNCH_I, AC97_DATA_OUT_I, ADC_LEFT_I, ADC_RIGHT_I,
    input  AC97_DATA_IN_O, PCM_LEFT_O, PCM_RIGHT_O, PCM_VALID_O,
           DAC_RATE_O, CODEC_READY_O
  );

  modport slave (
    input  AC97_SYNCH_I, AC97_DATA_OUT_I, ADC_LEFT_I, ADC_RIGHT_I,
    output AC97_DATA_IN_O, PCM_LEFT_O, PCM_RIGHT_O, PCM_VALID_O,
           DAC_RATE_O, CODEC_READY_O
  );
endinterface

// File: rtl/ac97_codec_link.sv
// ---------------------------------------------------------------------------
// ac97_codec_link
// Codec-side AC-link endpoint. Deserialises slots 0-4 of each incoming frame,
// executes register writes/reads, decodes playback PCM, and serialises the
// outgoing frame (status, read response, capture PCM).
// Ports:
//   BIT_CLOCK_I    bit clock, all logic on its rising edge
//   AC97_RESETN_I  asynchronous active-low reset
//   link           ac97_codec_link_if.slave (serial lines, samples, status)
// Parameters:
//   READY_FRAMES   frame starts after reset before codec-ready asserts
//   VENDOR_ID1/2   read values of registers 7Ch/7Eh
// ---------------------------------------------------------------------------
module ac97_codec_link #(
  parameter int          READY_FRAMES = 4,
  parameter logic [15:0] VENDOR_ID1   = 16'h4144,
  parameter logic [15:0] VENDOR_ID2   = 16'h5370
) (
  input logic              BIT_CLOCK_I,
  input logic              AC97_RESETN_I,
  ac97_codec_link_if.slave link
);

  localparam logic [7:0] CNT_IDLE = 8'hFF;
  localparam logic [7:0] CMD_CNT  = 8'd55;  // bits 0..55 (slots 0-2) held
  localparam logic [7:0] PCM_CNT  = 8'd95;  // bits 0..95 (slots 0-4) held

  // Register indices are byte address >> 1.
  localparam logic [5:0] IDX_RESET = 6'h00;  // 00h
  localparam logic [5:0] IDX_PWR   = 6'h13;  // 26h
  localparam logic [5:0] IDX_DAC   = 6'h16;  // 2Ch
  localparam logic [5:0] IDX_ADC   = 6'h19;  // 32h
  localparam logic [5:0] IDX_VID1  = 6'h3E;  // 7Ch
  localparam logic [5:0] IDX_VID2  = 6'h3F;  // 7Eh

  function automatic logic [15:0] reg_default(input logic [5:0] idx);
    case (idx)
      IDX_PWR:          return 16'h000F;
      IDX_DAC, IDX_ADC: return 16'hBB80;
      default:          return 16'h0000;
    endcase
  endfunction

  logic        sync_q, sync_d;
  logic [7:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        ready_q, ready_d;
  logic [95:0] rx_q, rx_d;       // newest bit at [0]
  logic [95:0] tx_q, tx_d;       // next bit to send at [95]
  logic        data_in_q, data_in_d;
  logic        pending_q, pending_d;
  logic [6:0]  rsp_addr_q, rsp_addr_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic [15:0] pcm_left_q, pcm_left_d;
  logic [15:0] pcm_right_q, pcm_right_d;
  logic        pcm_valid_q, pcm_valid_d;
  logic [15:0] regs_q [64];
  logic [15:0] regs_d [64];

  logic        frame_start, cmd_ok, wr_en, rd_en, play_ok;
  logic [6:0]  cmd_addr;
  logic [5:0]  cmd_idx;
  logic [15:0] cmd_data, rd_val;
  logic [95:0] tx_frame;

  always_comb begin
    // NOTE: every signal assigned here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch.
    sync_d      = link.AC97_SYNCH_I;
    frame_start = link.AC97_SYNCH_I & ~sync_q;

    // Frame start realigns at any counter value; otherwise count to idle.
    if (frame_start)                bit_cnt_d = 8'd0;
    else if (bit_cnt_q == CNT_IDLE) bit_cnt_d = CNT_IDLE;
    else                            bit_cnt_d = bit_cnt_q + 8'd1;

    frame_cnt_d = frame_cnt_q;
    if (frame_start && frame_cnt_q != 8'hFF) frame_cnt_d = frame_cnt_q + 8'd1;
    // The frame that reaches the threshold already advertises ready.
    ready_d = (frame_cnt_d >= 8'(READY_FRAMES));

    rx_d = {rx_q[94:0], link.AC97_DATA_OUT_I};

    // At CMD_CNT: slot0 = rx_q[55:40], slot1 = rx_q[39:20], slot2 = rx_q[19:0].
    cmd_addr = rx_q[38:32];
    cmd_idx  = cmd_addr[6:1];
    cmd_data = rx_q[19:4];
    cmd_ok   = !frame_start && (bit_cnt_q == CMD_CNT) && ready_q &&
               rx_q[55] && rx_q[54];
    wr_en    = cmd_ok && !rx_q[39] && rx_q[53];
    rd_en    = cmd_ok && rx_q[39];

    // At PCM_CNT: slot0 = rx_q[95:80], slot3 = rx_q[39:20], slot4 = rx_q[19:0].
    play_ok  = !frame_start && (bit_cnt_q == PCM_CNT) &&
               rx_q[95] && rx_q[92] && rx_q[91];

    case (cmd_idx)
      IDX_RESET: rd_val = 16'h0000;
      IDX_VID1:  rd_val = VENDOR_ID1;
      IDX_VID2:  rd_val = VENDOR_ID2;
      default:   rd_val = regs_q[cmd_idx];
    endcase

    for (int i = 0; i < 64; i++) regs_d[i] = regs_q[i];
    if (wr_en) begin
      case (cmd_idx)
        IDX_RESET: for (int i = 0; i < 64; i++) regs_d[i] = reg_default(6'(i));
        IDX_VID1, IDX_VID2: ;  // read-only vendor IDs
        IDX_PWR:   regs_d[cmd_idx] = cmd_data | 16'h000F;  // status nibble stays 1
        default:   regs_d[cmd_idx] = cmd_data;
      endcase
    end

    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    if (rd_en) begin
      rsp_addr_d = cmd_addr;
      rsp_data_d = rd_val;
    end

    tx_frame = {ready_d, pending_q, pending_q, ready_d, ready_d, 11'h000,
                pending_q ? {1'b0, rsp_addr_q, 12'h000} : 20'h0,
                pending_q ? {rsp_data_q, 4'h0}          : 20'h0,
                ready_d   ? {link.ADC_LEFT_I, 4'h0}     : 20'h0,
                ready_d   ? {link.ADC_RIGHT_I, 4'h0}    : 20'h0};

    // The shifter drains to zero, so the line idles low after slot 4.
    if (frame_start) begin
      data_in_d = tx_frame[95];
      tx_d      = {tx_frame[94:0], 1'b0};
      pending_d = 1'b0;  // the response rides in the frame starting now
    end else begin
      data_in_d = tx_q[95];
      tx_d      = {tx_q[94:0], 1'b0};
      pending_d = pending_q | rd_en;
    end

    pcm_valid_d = play_ok;
    pcm_left_d  = play_ok ? rx_q[39:24] : pcm_left_q;
    pcm_right_d = play_ok ? rx_q[19:4]  : pcm_right_q;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge BIT_CLOCK_I or negedge AC97_RESETN_I) begin
    if (!AC97_RESETN_I) begin
      sync_q      <= 1'b0;
      bit_cnt_q   <= CNT_IDLE;
      frame_cnt_q <= 8'd0;
      ready_q     <= 1'b0;
      rx_q        <= '0;
      tx_q        <= '0;
      data_in_q   <= 1'b0;
      pending_q   <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      pcm_left_q  <= '0;
      pcm_right_q <= '0;
      pcm_valid_q <= 1'b0;
      // NOTE: the register file is reset because its defaults are
      // architecturally visible (DAC rate, power status) from the first read.
      for (int i = 0; i < 64; i++) regs_q[i] <= reg_default(6'(i));
    end else begin
      sync_q      <= sync_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      ready_q     <= ready_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      data_in_q   <= data_in_d;
      pending_q   <= pending_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      pcm_left_q  <= pcm_left_d;
      pcm_right_q <= pcm_right_d;
      pcm_valid_q <= pcm_valid_d;
      regs_q      <= regs_d;
    end
  end

  assign link.AC97_DATA_IN_O = data_in_q;
  assign link.PCM_LEFT_O     = pcm_left_q;
  assign link.PCM_RIGHT_O    = pcm_right_q;
  assign link.PCM_VALID_O    = pcm_valid_q;
  assign link.DAC_RATE_O     = regs_q[IDX_DAC];
  assign link.CODEC_READY_O  = ready_q;

endmodule

// File: tb/tb_ac97_codec_link.sv
// ---------------------------------------------------------------------------
// tb_ac97_codec_link
// Drives AC-link frames bit by bit, captures the returned serial frame and
// compares it, the decoded PCM, DAC rate and ready status against a
// frame-level reference model of the codec.
// ---------------------------------------------------------------------------
module tb_ac97_codec_link;
  localparam int          READY_FRAMES = 4;
  localparam logic [15:0] VID1 = 16'h4144;
  localparam logic [15:0] VID2 = 16'h5370;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ac97_codec_link_if link();

  ac97_codec_link #(
    .READY_FRAMES(READY_FRAMES),
    .VENDOR_ID1  (VID1),
    .VENDOR_ID2  (VID2)
  ) dut (
    .BIT_CLOCK_I  (clk),
    .AC97_RESETN_I(rst_n),
    .link         (link)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int          frames_m;
  logic [15:0] regs_m [64];
  bit          pend_m;
  logic [6:0]  rsp_addr_m;
  logic [15:0] rsp_data_m;
  logic [15:0] pcm_l_m, pcm_r_m;
  logic [15:0] adc_l, adc_r;

  function automatic logic [15:0] default_of(input logic [6:0] byte_addr);
    case (byte_addr)
      7'h26:        return 16'h000F;
      7'h2C, 7'h32: return 16'hBB80;
      default:      return 16'h0000;
    endcase
  endfunction

  function automatic void model_defaults();
    for (int i = 0; i < 64; i++) regs_m[i] = default_of(7'(i * 2));
  endfunction

  function automatic void model_reset();
    frames_m = 0;
    pend_m   = 0;
    pcm_l_m  = 16'h0;
    pcm_r_m  = 16'h0;
    model_defaults();
  endfunction

  function automatic logic [15:0] model_read(input logic [6:0] a);
    logic [6:0] b;
    b = {a[6:1], 1'b0};
    case (b)
      7'h00:   return 16'h0000;
      7'h7C:   return VID1;
      7'h7E:   return VID2;
      default: return regs_m[b / 2];
    endcase
  endfunction

  function automatic void model_write(input logic [6:0] a, input logic [15:0] d);
    logic [6:0] b;
    b = {a[6:1], 1'b0};
    case (b)
      7'h00:        model_defaults();
      7'h7C, 7'h7E: ;
      7'h26:        regs_m[b / 2] = d | 16'h000F;
      default:      regs_m[b / 2] = d;
    endcase
  endfunction

  // ---------------- frame driver / capture ----------------
  logic [255:0] tx_cap;
  logic [15:0]  dac_s   [0:256];
  logic         valid_s [0:256];
  logic         ready_s1;

  task automatic run_frame(input logic [15:0] s0, input logic [19:0] s1, s2, s3, s4,
                           input int nbits);
    logic [255:0] rx;
    logic [15:0]  e0, dac_pre, dac_post;
    logic [19:0]  e1, e2, e3, e4;
    bit           rdy, pulse;

    rx = {s0, s1, s2, s3, s4, 160'h0};
    if (frames_m < 255) frames_m++;
    rdy = (frames_m >= READY_FRAMES);
    e0  = {rdy, pend_m, pend_m, rdy, rdy, 11'h0};
    e1  = pend_m ? {1'b0, rsp_addr_m, 12'h0} : 20'h0;
    e2  = pend_m ? {rsp_data_m, 4'h0} : 20'h0;
    e3  = rdy ? {adc_l, 4'h0} : 20'h0;
    e4  = rdy ? {adc_r, 4'h0} : 20'h0;
    pend_m  = 0;
    dac_pre = model_read(7'h2C);
    if (nbits >= 57 && rdy && s0[15] && s0[14]) begin
      if (s1[19]) begin
        pend_m     = 1;
        rsp_addr_m = s1[18:12];
        rsp_data_m = model_read(s1[18:12]);
      end else if (s0[13]) begin
        model_write(s1[18:12], s2[19:4]);
      end
    end
    dac_post = model_read(7'h2C);
    pulse = (nbits >= 97) && s0[15] && s0[12] && s0[11];
    if (pulse) begin
      pcm_l_m = s3[19:4];
      pcm_r_m = s4[19:4];
    end

    link.ADC_LEFT_I  = adc_l;
    link.ADC_RIGHT_I = adc_r;
    tx_cap = '0;
    for (int k = 0; k <= nbits; k++) begin
      @(negedge clk);
      if (k > 0) tx_cap[256 - k] = link.AC97_DATA_IN_O;
      dac_s[k]   = link.DAC_RATE_O;
      valid_s[k] = link.PCM_VALID_O;
      if (k == 1) ready_s1 = link.CODEC_READY_O;
      if (k < nbits) begin
        link.AC97_SYNCH_I    = (k < 16);
        link.AC97_DATA_OUT_I = rx[255 - k];
      end else begin
        link.AC97_SYNCH_I    = 1'b0;
        link.AC97_DATA_OUT_I = 1'b0;
      end
    end

    check("codec_ready", 32'(ready_s1), 32'(rdy));
    if (nbits >= 16) check("tx_slot0", 32'(tx_cap[255:240]), 32'(e0));
    if (nbits >= 36) check("tx_slot1", 32'(tx_cap[239:220]), 32'(e1));
    if (nbits >= 56) check("tx_slot2", 32'(tx_cap[219:200]), 32'(e2));
    if (nbits >= 76) check("tx_slot3", 32'(tx_cap[199:180]), 32'(e3));
    if (nbits >= 96) check("tx_slot4", 32'(tx_cap[179:160]), 32'(e4));
    if (nbits >= 58) begin
      check("dac_before_cmd", 32'(dac_s[56]), 32'(dac_pre));
      check("dac_after_cmd",  32'(dac_s[57]), 32'(dac_post));
    end
    if (nbits >= 98) begin
      check("pcm_valid_early", 32'(valid_s[96]), 32'h0);
      check("pcm_valid_pulse", 32'(valid_s[97]), 32'(pulse));
      check("pcm_valid_late",  32'(valid_s[98]), 32'h0);
    end
    check("pcm_left",  32'(link.PCM_LEFT_O),  32'(pcm_l_m));
    check("pcm_right", 32'(link.PCM_RIGHT_O), 32'(pcm_r_m));
  endtask

  task automatic check_reset_outputs();
    check("rst_data_in",   32'(link.AC97_DATA_IN_O), 32'h0);
    check("rst_pcm_left",  32'(link.PCM_LEFT_O),     32'h0);
    check("rst_pcm_right", 32'(link.PCM_RIGHT_O),    32'h0);
    check("rst_pcm_valid", 32'(link.PCM_VALID_O),    32'h0);
    check("rst_dac_rate",  32'(link.DAC_RATE_O),     32'hBB80);
    check("rst_ready",     32'(link.CODEC_READY_O),  32'h0);
  endtask

  initial begin
    logic [15:0] s0;
    logic [19:0] s1;
    logic [6:0]  a;

    link.AC97_SYNCH_I    = 1'b0;
    link.AC97_DATA_OUT_I = 1'b0;
    adc_l = 16'h0;
    adc_r = 16'h0;
    link.ADC_LEFT_I  = 16'h0;
    link.ADC_RIGHT_I = 16'h0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ready sequencing: three frames not ready, fourth advertises ready.
    repeat (3) run_frame(16'h0, 20'h0, 20'h0, 20'h0, 20'h0, 256);
    check("pre_ready_slot0", 32'(tx_cap[255:240]), 32'h0000);
    run_frame(16'h0, 20'h0, 20'h0, 20'h0, 20'h0, 256);
    check("ready_slot0", 32'(tx_cap[255:240]), 32'h9800);
    check("ready_flag",  32'(ready_s1), 32'h1);

    // Write 2Ch, then read it back.
    run_frame(16'hE000, 20'h2C000, 20'hAC440, 20'h0, 20'h0, 256);
    check("wr2c_dac", 32'(dac_s[57]), 32'hAC44);
    run_frame(16'hC000, 20'hAC000, 20'h0, 20'h0, 20'h0, 256);
    run_frame(16'hC000, 20'hFC000, 20'h0, 20'h0, 20'h0, 256);   // read 7Ch
    check("rd2c_slot0", 32'(tx_cap[255:240]), 32'hF800);
    check("rd2c_slot1", 32'(tx_cap[239:220]), 32'h2C000);
    check("rd2c_slot2", 32'(tx_cap[219:200]), 32'hAC440);
    run_frame(16'hE000, 20'h7C000, 20'h12340, 20'h0, 20'h0, 256); // write 7Ch
    check("rd7c_slot2", 32'(tx_cap[219:200]), 32'h41440);
    run_frame(16'hC000, 20'hFC000, 20'h0, 20'h0, 20'h0, 256);
    run_frame(16'hE000, 20'h26000, 20'h00000, 20'h0, 20'h0, 256); // write 26h
    check("rd7c_ro_slot2", 32'(tx_cap[219:200]), 32'h41440);
    run_frame(16'hC000, 20'hA6000, 20'h0, 20'h0, 20'h0, 256);

    // Playback valid, then playback with slot4 tag cleared.
    run_frame(16'h9800, 20'h0, 20'h0, 20'h12345, 20'hABCDE, 256);
    check("rd26_slot2", 32'(tx_cap[219:200]), 32'h000F0);
    check("pcm_left_dir",  32'(link.PCM_LEFT_O),  32'h1234);
    check("pcm_right_dir", 32'(link.PCM_RIGHT_O), 32'hABCD);
    check("pcm_pulse_dir", 32'(valid_s[97]), 32'h1);
    run_frame(16'h9000, 20'h0, 20'h0, 20'h55555, 20'h66666, 256);
    check("pcm_nopulse_dir", 32'(valid_s[97]), 32'h0);
    check("pcm_hold_dir",    32'(link.PCM_LEFT_O), 32'h1234);

    // Capture samples.
    adc_l = 16'h5A5A;
    adc_r = 16'hA5A5;
    run_frame(16'h0, 20'h0, 20'h0, 20'h0, 20'h0, 256);
    check("adc_slot3", 32'(tx_cap[199:180]), 32'h5A5A0);
    check("adc_slot4", 32'(tx_cap[179:160]), 32'hA5A50);

    // Write 00h restores defaults.
    run_frame(16'hE000, 20'h00000, 20'h12340, 20'h0, 20'h0, 256);
    run_frame(16'hC000, 20'hAC000, 20'h0, 20'h0, 20'h0, 256);
    run_frame(16'h0, 20'h0, 20'h0, 20'h0, 20'h0, 256);
    check("defaults_slot2", 32'(tx_cap[219:200]), 32'hBB800);

    // Short frame cuts a write before bit 55: write dropped, link realigns.
    run_frame(16'hE000, 20'h2C000, 20'h11110, 20'h0, 20'h0, 40);
    run_frame(16'hC000, 20'hAC000, 20'h0, 20'h0, 20'h0, 256);
    check("short_wr_dropped", 32'(dac_s[57]), 32'hBB80);
    run_frame(16'h9800, 20'h0, 20'h0, 20'hCAFE1, 20'hBEEF2, 100);
    check("short_rsp_slot2", 32'(tx_cap[219:200]), 32'hBB800);
    run_frame(16'h0, 20'h0, 20'h0, 20'h0, 20'h0, 256);

    // Randomised traffic.
    for (int i = 0; i < 24; i++) begin
      a     = ($urandom_range(0, 3) == 0) ? 7'h2C : 7'($urandom_range(0, 127));
      adc_l = 16'($urandom);
      adc_r = 16'($urandom);
      case ($urandom_range(0, 3))
        0: begin s0 = {3'b111, 2'($urandom), 11'($urandom)};       s1 = {1'b0, a, 12'($urandom)}; end
        1: begin s0 = {2'b11, 3'($urandom), 11'($urandom)};        s1 = {1'b1, a, 12'($urandom)}; end
        2: begin s0 = 16'($urandom);                                s1 = 20'($urandom);            end
        default: begin s0 = {1'b1, 2'($urandom), 2'b11, 11'($urandom)}; s1 = 20'($urandom);      end
      endcase
      run_frame(s0, s1, 20'($urandom), 20'($urandom), 20'($urandom), 256);
    end

    // Reset in the middle of a frame with a read pending.
    run_frame(16'hE000, 20'h2C000, 20'h13570, 20'h0, 20'h0, 256);
    run_frame(16'hD800, 20'hAC000, 20'h0, 20'h0, 20'h0, 70);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(16'h0, 20'h0, 20'h0, 20'h0, 20'h0, 256);
    check("post_rst_slot0", 32'(tx_cap[255:240]), 32'h0000);
    repeat (2) run_frame(16'h0, 20'h0, 20'h0, 20'h0, 20'h0, 256);
    check("post_rst_not_ready", 32'(ready_s1), 32'h0);
    run_frame(16'h0, 20'h0, 20'h0, 20'h0, 20'h0, 256);
    check("post_rst_ready", 32'(ready_s1), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
